mux_sel_ctrl: RTL and testbench
===============================

MUX_SEL_CTRL -- requirements
Module: mux_sel_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive clock cycles a synchronized key change must persist before it is accepted (legal range 2..65535).
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000, meaning the clock cycles per select step in auto-scan mode (legal range 2..2^24-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port key, input, 1 bit: raw asynchronous pushbutton, active-high, bouncing.
REQ-006 The block SHALL have port mode, input, 1 bit: 0 = manual stepping by key, 1 = auto-scan.
REQ-007 The block SHALL have port hold, input, 1 bit: in auto-scan, 1 freezes sel and the prescaler.
REQ-008 The block SHALL have port sel, output, 2 bits: registered select code driving the downstream 4:1 mux / 7-segment stage.
REQ-009 The block SHALL have port step, output, 1 bit: registered one-cycle pulse, high in exactly the cycles in which sel has just changed.
REQ-010 The block SHALL have port key_level, output, 1 bit: registered debounced key level.

Function
REQ-011 key SHALL pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-012 Debounce counter: cleared in any cycle s2 == key_level; incremented when s2 != key_level; when it equals DEBOUNCE_CYCLES-1 with s2 != key_level, key_level <= s2 and counter <= 0.
REQ-013 A press event SHALL be key_level == 1 while its one-cycle-delayed copy == 0; release events SHALL have no effect.
REQ-014 Manual mode (mode=0): each press event SHALL advance sel by 1 modulo 4 (11 -> 00 wrap) on the next edge; hold is ignored.
REQ-015 Manual latency: with key stable high from edge k onward, sel SHALL change at edge k+DEBOUNCE_CYCLES+2 and never again until a release and a new press.
REQ-016 Auto mode (mode=1, hold=0): the prescaler SHALL count 0..SCAN_DIV-1; on the edge where it equals SCAN_DIV-1, sel advances by 1 modulo 4 and the prescaler returns to 0.
REQ-017 Auto mode with hold=1: prescaler and sel SHALL keep their values; counting resumes from the held prescaler value when hold falls.
REQ-018 Press events in auto mode SHALL be ignored (no sel change, no queued step); debouncing and key_level SHALL continue to operate.
REQ-019 Whenever mode=0, the prescaler SHALL be held at 0, so the first auto step occurs SCAN_DIV edges after mode rises.
REQ-020 sel SHALL advance at most by 1 per cycle regardless of coincident events; on the edge mode changes, the increment source SHALL be the mode value sampled on that edge.
REQ-021 step SHALL be asserted on the same edge sel updates and deasserted on the next edge unless sel updates again.

Reset
REQ-022 With rst=1 at an edge: sel=00, step=0, key_level=0, s1=s2=0, debounce counter=0, prescaler=0, press-delay flop=0.
REQ-023 rst SHALL take priority over every other input, including mid-debounce and mid-scan; in-progress counts are discarded and no step pulse is generated.
REQ-024 On the first edge after rst falls, operation SHALL resume from the reset state; a key held high through reset SHALL be seen as a fresh press after full debounce.

Verification
REQ-025 DEBOUNCE_CYCLES=4, mode=0: reset, key high from edge 10 -> sel 00->01 and step=1 at edge 16 only; key_level=1 from edge 15.
REQ-026 DEBOUNCE_CYCLES=4, mode=0: key toggling every 2 cycles for 40 cycles, then low -> sel stays 00, step never asserted, key_level stays 0.
REQ-027 Four clean presses in manual mode -> sel 01,10,11,00 (wrap), exactly four single-cycle step pulses.
REQ-028 SCAN_DIV=4: mode raised at edge 20 -> sel steps at edges 24,28,32,...; hold high during edges 25..30 -> step lands at edge 34 instead of 28, then every 4 edges.
REQ-029 Auto mode with key pressed and debounced -> no extra sel step; rst asserted mid-scan with prescaler=2 -> next edge sel=00, prescaler=0, step=0.

Source files
------------

// File: rtl/mux_sel_ctrl.sv
// Debounced pushbutton / auto-scan controller producing a 2-bit mux select and a step strobe.
// Latency: key to sel is DEBOUNCE_CYCLES+2 edges; auto step every SCAN_DIV edges. No backpressure.
module mux_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic       mode,
    input  logic       hold,
    output logic [1:0] sel,
    output logic       step,
    output logic       key_level
);

    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] SCAN_LAST = 24'(SCAN_DIV - 1);

    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic [15:0] db_cnt_q, db_cnt_d;
    logic        key_level_q, key_level_d;
    logic        press_dly_q, press_dly_d;
    logic [23:0] presc_q, presc_d;
    logic [1:0]  sel_q, sel_d;
    logic        step_q, step_d;
    logic        press;
    logic        adv;

    always_comb begin
        s1_d        = key;
        s2_d        = s1_q;
        db_cnt_d    = db_cnt_q;
        key_level_d = key_level_q;
        press_dly_d = key_level_q;
        presc_d     = presc_q;
        adv         = 1'b0;

        // A change must survive DEBOUNCE_CYCLES consecutive samples to be accepted.
        if (s2_q == key_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            key_level_d = s2_q;
            db_cnt_d    = '0;
        end else begin
            db_cnt_d = db_cnt_q + 16'd1;
        end

        press = key_level_q & ~press_dly_q;

        // Only one increment source is live per edge, selected by the sampled mode.
        if (!mode) begin
            presc_d = '0;
            adv     = press;
        end else if (!hold) begin
            if (presc_q == SCAN_LAST) begin
                presc_d = '0;
                adv     = 1'b1;
            end else begin
                presc_d = presc_q + 24'd1;
            end
        end

        sel_d  = adv ? sel_q + 2'd1 : sel_q;
        step_d = adv;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            db_cnt_q    <= '0;
            key_level_q <= 1'b0;
            press_dly_q <= 1'b0;
            presc_q     <= '0;
            sel_q       <= 2'd0;
            step_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            db_cnt_q    <= db_cnt_d;
            key_level_q <= key_level_d;
            press_dly_q <= press_dly_d;
            presc_q     <= presc_d;
            sel_q       <= sel_d;
            step_q      <= step_d;
        end
    end

    assign sel       = sel_q;
    assign step      = step_q;
    assign key_level = key_level_q;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed vector bench for mux_sel_ctrl with DEBOUNCE_CYCLES=4, SCAN_DIV=4.
// Edge e of a scenario is the e-th edge after reset is released; inputs for edge e are driven before it.
module tb_mux_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b0;
    logic       mode = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] sel;
    logic       step;
    logic       key_level;

    mux_sel_ctrl #(.DEBOUNCE_CYCLES(4), .SCAN_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .mode      (mode),
        .hold      (hold),
        .sel       (sel),
        .step      (step),
        .key_level (key_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         scn;
        int         e;
        logic       rst;
        logic       key;
        logic       mode;
        logic       hold;
        logic [1:0] sel;
        logic       step;
        logic       kl;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void push(int scn, int e, logic r, logic k, logic m, logic h,
                                 logic [1:0] s, logic st, logic kl);
        vec_t v;
        v.scn = scn; v.e = e; v.rst = r; v.key = k; v.mode = m; v.hold = h;
        v.sel = s; v.step = st; v.kl = kl;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, int scn, int e, int got, int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s scn%0d e%0d: got %0d want %0d", name, scn, e, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int waited;
        bit seen;

        // A: key high from edge 10 -> key_level at 15, sel 01 + step at 16; then release.
        for (int i = 0; i < 3; i++) push(1, -i, 1, 0, 0, 0, 2'd0, 0, 0);
        for (int e = 1; e <= 32; e++)
            push(1, e, 0, (e >= 10 && e <= 20), 0, 0,
                 (e >= 16) ? 2'd1 : 2'd0, (e == 16), (e >= 15 && e < 26));

        // B: key toggling every 2 cycles never passes debounce.
        for (int i = 0; i < 2; i++) push(2, -i, 1, 0, 0, 0, 2'd0, 0, 0);
        for (int e = 1; e <= 50; e++)
            push(2, e, 0, (e <= 40) ? logic'(((e - 1) >> 1) & 1) : 1'b0, 0, 0, 2'd0, 0, 0);

        // C: four clean presses with hold toggling (ignored in manual) -> 01,10,11,00.
        for (int i = 0; i < 2; i++) push(3, -i, 1, 0, 0, 0, 2'd0, 0, 0);
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 16; i++)
                push(3, 1 + 16 * p + i, 0, (i < 8), 0, logic'(i & 1),
                     (i >= 6) ? 2'((p + 1) % 4) : 2'(p % 4), (i == 6), (i >= 5 && i < 13));

        // D: auto scan with hold, key press ignored, reset mid-scan with prescaler at 2.
        for (int i = 0; i < 2; i++) push(4, -i, 1, 0, 0, 0, 2'd0, 0, 0);
        n = 0;
        for (int e = 1; e <= 60; e++) begin
            bit st;
            st = (e == 24) || (e >= 34 && (e - 34) % 4 == 0);
            if (st) n++;
            push(4, e, 0, (e >= 45), (e >= 21), (e >= 25 && e <= 30), 2'(n % 4), st, (e >= 50));
        end
        push(4, 61, 1, 1, 1, 0, 2'd0, 0, 0);
        n = 0;
        for (int e = 62; e <= 72; e++) begin
            bit st;
            st = (e == 65) || (e == 69);
            if (st) n++;
            push(4, e, 0, 1, 1, 0, 2'(n % 4), st, (e >= 67));
        end

        // E: key held through reset is a fresh press after full debounce, and only one step.
        for (int i = 0; i < 3; i++) push(5, -i, 1, 1, 0, 0, 2'd0, 0, 0);
        for (int e = 1; e <= 20; e++)
            push(5, e, 0, 1, 0, 0, (e >= 7) ? 2'd1 : 2'd0, (e == 7), (e >= 6));

        for (int i = 0; i < vecs.size(); i++) begin
            rst  = vecs[i].rst;
            key  = vecs[i].key;
            mode = vecs[i].mode;
            hold = vecs[i].hold;
            tick();
            check("sel", vecs[i].scn, vecs[i].e, int'(sel), int'(vecs[i].sel));
            check("step", vecs[i].scn, vecs[i].e, int'(step), int'(vecs[i].step));
            check("key_level", vecs[i].scn, vecs[i].e, int'(key_level), int'(vecs[i].kl));
        end

        // Hand sequence: auto mode straight out of reset, bounded wait for the first step.
        rst = 1'b1; key = 1'b0; mode = 1'b1; hold = 1'b0;
        tick();
        rst = 1'b0;
        waited = 0;
        seen = 1'b0;
        while (!seen && waited < 20) begin
            tick();
            waited++;
            if (step) seen = 1'b1;
        end
        check("first_auto_step_seen", 6, waited, int'(seen), 1);
        check("first_auto_step_edge", 6, waited, waited, 4);
        check("first_auto_step_sel", 6, waited, int'(sel), 1);
        tick();
        check("step_width", 6, waited + 1, int'(step), 0);
        check("sel_after_step", 6, waited + 1, int'(sel), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
